// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and helpers for the parametrised 1RW1R SRAM
//   sram_state_e : CLEAR (post-reset zeroing) / RUN (accepting requests)
//   depth_of     : words in the array for a given address width
//   lane_width   : bits per write-enable lane
//   lane_merge   : replace the masked lanes of a word with new data
package sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } sram_state_e;

  // Upper bounds for the generic merge helper; callers zero-extend into these.
  localparam int MAX_DATA_WIDTH = 1024;
  localparam int MAX_MASK_WIDTH = 128;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int lane_width(input int data_width, input int mask_width);
    return data_width / mask_width;
  endfunction

  // Lane i of the result comes from new_word when mask[i] is set, else old_word.
  function automatic logic [MAX_DATA_WIDTH-1:0] lane_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_MASK_WIDTH-1:0] mask,
    input int                        lane_w
  );
    logic [MAX_DATA_WIDTH-1:0] bit_en;
    logic [MAX_MASK_WIDTH-1:0] sh;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      sh        = mask >> (i / lane_w);
      bit_en[i] = sh[0];
    end
    return (old_word & ~bit_en) | (new_word & bit_en);
  endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// rtl/sram_read_pipe.sv - read output register stage(s) for one port
//   clk, rst_n  : clock, async active-low reset (flushes the pipe)
//   rd_en       : read accepted this cycle
//   rd_word     : word read (already bypass-merged where relevant)
//   coll_in     : this read hit a same-cycle write (used only when COLL != 0)
//   rdata       : read data, holds its value while rvalid is low
//   rvalid      : one-cycle pulse per accepted read
//   collision   : pulse coincident with rvalid for a colliding read
module sram_read_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int COLL         = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_word,
  input  logic                  coll_in,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  collision
);

  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;
  logic                  s1_coll;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_coll  <= 1'b0;
    end else begin
      s1_valid <= rd_en;
      s1_coll  <= (COLL != 0) && rd_en && coll_in;
      if (rd_en) s1_data <= rd_word;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata     <= '0;
          rvalid    <= 1'b0;
          collision <= 1'b0;
        end else begin
          rvalid    <= s1_valid;
          collision <= s1_coll;
          if (s1_valid) rdata <= s1_data;
        end
      end
    end else begin : g_lat1
      assign rdata     = s1_data;
      assign rvalid    = s1_valid;
      assign collision = s1_coll;
    end
  endgenerate

endmodule

// File: rtl/sram_1rw1r_param.sv
// rtl/sram_1rw1r_param.sv - parametrised single-clock 1RW1R memory with clear sequencer
//   clk, rst_n                  : clock, async active-low reset
//   ready                       : requests accepted while high
//   p0_req/we/wmask/addr/wdata  : read/write port request
//   p0_rdata, p0_rvalid         : port 0 read response
//   p1_req/addr                 : read-only port request
//   p1_rdata, p1_rvalid         : port 1 read response
//   collision                   : p1 read returned data bypassed from a same-cycle p0 write
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 9,
  parameter int WMASK_WIDTH    = 4,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   ready,
  input  logic                   p0_req,
  input  logic                   p0_we,
  input  logic [WMASK_WIDTH-1:0] p0_wmask,
  input  logic [ADDR_WIDTH-1:0]  p0_addr,
  input  logic [DATA_WIDTH-1:0]  p0_wdata,
  output logic [DATA_WIDTH-1:0]  p0_rdata,
  output logic                   p0_rvalid,
  input  logic                   p1_req,
  input  logic [ADDR_WIDTH-1:0]  p1_addr,
  output logic [DATA_WIDTH-1:0]  p1_rdata,
  output logic                   p1_rvalid,
  output logic                   collision
);

  localparam int DEPTH  = depth_of(ADDR_WIDTH);
  localparam int LANE_W = lane_width(DATA_WIDTH, WMASK_WIDTH);

  sram_state_e           state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  p0_write, p0_read, p1_read, p1_coll;
  logic [DATA_WIDTH-1:0] write_word, p1_word;
  logic                  p0_coll_q, p1_coll_q;

  // Clear sequencer: one word per cycle, ready rises the cycle after the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cnt   <= '0;
      ready <= 1'b0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (&cnt) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end else begin
      ready <= 1'b1;
    end
  end

  assign p0_write = ready && p0_req && p0_we;
  assign p0_read  = ready && p0_req && !p0_we;
  assign p1_read  = ready && p1_req;
  assign p1_coll  = p0_write && p1_read && (p0_addr == p1_addr);

  // The merged write word doubles as the write-first bypass value for p1.
  assign write_word = DATA_WIDTH'(lane_merge(MAX_DATA_WIDTH'(mem[p0_addr]),
                                             MAX_DATA_WIDTH'(p0_wdata),
                                             MAX_MASK_WIDTH'(p0_wmask),
                                             LANE_W));
  assign p1_word    = p1_coll ? write_word : mem[p1_addr];

  // Array has no reset; contents are only defined after CLEAR or a write.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (p0_write) begin
      mem[p0_addr] <= write_word;
    end
  end

  sram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY),
    .COLL        (0)
  ) u_p0_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (p0_read),
    .rd_word  (mem[p0_addr]),
    .coll_in  (1'b0),
    .rdata    (p0_rdata),
    .rvalid   (p0_rvalid),
    .collision(p0_coll_q)
  );

  sram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY),
    .COLL        (1)
  ) u_p1_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (p1_read),
    .rd_word  (p1_word),
    .coll_in  (p1_coll),
    .rdata    (p1_rdata),
    .rvalid   (p1_rvalid),
    .collision(p1_coll_q)
  );

  // p0's pipe never flags (its coll_in is tied low); OR-ing keeps the port structure uniform.
  assign collision = p1_coll_q | p0_coll_q;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// tb/tb_sram_1rw1r_param.sv - randomized model-checked bench for two sram_1rw1r_param configurations
module tb_sram_1rw1r_param;

  typedef struct {
    int          due;
    logic [63:0] data;
    bit          coll;
  } rd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: 32x512, 4 lanes, latency 1, clear on reset.
  // Index 1: 64x16, 8 lanes, latency 2, no clear.
  logic        rst   [2];
  logic        req0  [2];
  logic        we    [2];
  logic        req1  [2];
  logic [7:0]  wmask [2];
  logic [8:0]  addr0 [2];
  logic [8:0]  addr1 [2];
  logic [63:0] wdata [2];
  logic        ready [2];

  // Output ports, flattened: k = 2*dut + port.
  logic [63:0] rd [4];
  logic        rv [4];
  logic        co [4];

  logic [31:0] a_rd0, a_rd1;
  logic [63:0] b_rd0, b_rd1;
  logic        a_coll, b_coll;

  sram_1rw1r_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(9), .WMASK_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .rst_n(rst[0]), .ready(ready[0]),
    .p0_req(req0[0]), .p0_we(we[0]), .p0_wmask(wmask[0][3:0]), .p0_addr(addr0[0]),
    .p0_wdata(wdata[0][31:0]), .p0_rdata(a_rd0), .p0_rvalid(rv[0]),
    .p1_req(req1[0]), .p1_addr(addr1[0]), .p1_rdata(a_rd1), .p1_rvalid(rv[1]),
    .collision(a_coll)
  );

  sram_1rw1r_param #(
    .DATA_WIDTH(64), .ADDR_WIDTH(4), .WMASK_WIDTH(8), .READ_LATENCY(2), .CLEAR_ON_RESET(0)
  ) dut_b (
    .clk(clk), .rst_n(rst[1]), .ready(ready[1]),
    .p0_req(req0[1]), .p0_we(we[1]), .p0_wmask(wmask[1]), .p0_addr(addr0[1][3:0]),
    .p0_wdata(wdata[1]), .p0_rdata(b_rd0), .p0_rvalid(rv[2]),
    .p1_req(req1[1]), .p1_addr(addr1[1][3:0]), .p1_rdata(b_rd1), .p1_rvalid(rv[3]),
    .collision(b_coll)
  );

  assign rd[0] = {32'b0, a_rd0};
  assign rd[1] = {32'b0, a_rd1};
  assign rd[2] = b_rd0;
  assign rd[3] = b_rd1;
  assign co[0] = 1'b0;
  assign co[1] = a_coll;
  assign co[2] = 1'b0;
  assign co[3] = b_coll;

  int thr   [2] = '{512, 1};
  int lat   [2] = '{1, 2};
  int nl    [2] = '{4, 8};
  int depth [2] = '{512, 16};
  bit clr   [2] = '{1'b1, 1'b0};

  logic [63:0] mm [2][512];
  rd_t         q  [4][$];
  logic [63:0] last [4];
  int          edges [2];
  int          cyc;
  int          tests;
  int          fails;

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] m, input int lanes);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < lanes; i++) if (m[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Apply one accepted edge's requests to the model: write first, then reads see the new word.
  task automatic accept(input int d);
    int  a0, a1;
    bit  wr, coll;
    rd_t e;
    a0   = int'(addr0[d]) % depth[d];
    a1   = int'(addr1[d]) % depth[d];
    wr   = req0[d] && we[d];
    coll = wr && req1[d] && (a0 == a1);
    if (wr) mm[d][a0] = merge(mm[d][a0], wdata[d], wmask[d], nl[d]);
    if (req0[d] && !we[d]) begin
      e.due = cyc + lat[d] - 1; e.data = mm[d][a0]; e.coll = 1'b0;
      q[2*d].push_back(e);
    end
    if (req1[d]) begin
      e.due = cyc + lat[d] - 1; e.data = mm[d][a1]; e.coll = coll;
      q[2*d+1].push_back(e);
    end
  endtask

  // Model: advances on every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (!rst[d]) begin
          q[2*d].delete();
          q[2*d+1].delete();
          last[2*d]   = '0;
          last[2*d+1] = '0;
          edges[d]    = 0;
        end else begin
          if (edges[d] >= thr[d]) accept(d);
          edges[d]++;
          if (clr[d] && edges[d] == depth[d])
            for (int a = 0; a < depth[d]; a++) mm[d][a] = '0;
        end
      end
    end
  end

  // Compare: every falling edge, all outputs of both DUTs against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d_ready", d), 64'(ready[d]), 64'(rst[d] && edges[d] >= thr[d]));
        for (int p = 0; p < 2; p++) begin
          int k;
          k = 2*d + p;
          if (!rst[d]) begin
            chk($sformatf("k%0d_rvalid_rst", k), 64'(rv[k]), 64'd0);
            chk($sformatf("k%0d_rdata_rst", k), rd[k], 64'd0);
          end else if (q[k].size() > 0 && q[k][0].due == cyc) begin
            chk($sformatf("k%0d_rvalid", k), 64'(rv[k]), 64'd1);
            chk($sformatf("k%0d_rdata", k), rd[k], q[k][0].data);
            if (p == 1) chk($sformatf("k%0d_collision", k), 64'(co[k]), 64'(q[k][0].coll));
            last[k] = q[k][0].data;
            void'(q[k].pop_front());
          end else begin
            chk($sformatf("k%0d_rvalid_idle", k), 64'(rv[k]), 64'd0);
            chk($sformatf("k%0d_rdata_hold", k), rd[k], last[k]);
            if (p == 1) chk($sformatf("k%0d_collision_idle", k), 64'(co[k]), 64'd0);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    req0[d] = 1'b0; we[d] = 1'b0; req1[d] = 1'b0; wmask[d] = '0;
    addr0[d] = '0; addr1[d] = '0; wdata[d] = '0;
  endtask

  task automatic op(input int d, input logic r0, input logic w, input logic [7:0] m,
                    input int a0, input logic [63:0] wd, input logic r1, input int a1);
    req0[d] = r0; we[d] = w; wmask[d] = m; addr0[d] = 9'(a0); wdata[d] = wd;
    req1[d] = r1; addr1[d] = 9'(a1);
    step();
    idle(d);
  endtask

  task automatic rand_req(input int d, input int amax);
    req0[d]  = ($urandom_range(0, 3) != 0);
    we[d]    = 1'($urandom_range(0, 1));
    wmask[d] = 8'($urandom_range(1, (1 << nl[d]) - 1));
    addr0[d] = 9'($urandom_range(0, amax));
    wdata[d] = {$urandom, $urandom};
    req1[d]  = 1'($urandom_range(0, 1));
    addr1[d] = ($urandom_range(0, 2) == 0) ? addr0[d] : 9'($urandom_range(0, amax));
  endtask

  // Hammers requests while not ready (they must be ignored) and measures the ready-low span.
  task automatic wait_ready(input int d, input int expn, input string nm);
    int n;
    n = 0;
    while (!ready[d] && n < 2000) begin
      rand_req(d, 15);
      step();
      n++;
    end
    idle(d);
    chk(nm, 64'(n), 64'(expn));
  endtask

  initial begin
    int cnt;
    tests = 0; fails = 0; cyc = 0;
    edges[0] = 0; edges[1] = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0;
      idle(d);
    end
    for (int k = 0; k < 4; k++) last[k] = '0;
    repeat (3) step();

    // ---------------- DUT A: 32x512, latency 1, clear on reset ----------------
    rst[0] = 1'b1;
    wait_ready(0, 512, "a_clear_len");

    op(0, 1, 1, 8'hF, 5, 64'hDEADBEEF, 0, 0);
    op(0, 1, 1, 8'h2, 5, 64'h0000AA00, 0, 0);
    chk("a_model_addr5", mm[0][5], 64'hDEADAAEF);
    op(0, 1, 0, 8'h0, 5, 64'h0, 0, 0);
    chk("a_p0_rd5_valid", 64'(rv[0]), 64'd1);
    chk("a_p0_rd5_data", rd[0], 64'hDEADAAEF);

    op(0, 1, 1, 8'hF, 7, 64'hAABBCCDD, 0, 0);
    op(0, 1, 1, 8'hC, 7, 64'h11223344, 1, 7);
    chk("a_coll_valid", 64'(rv[1]), 64'd1);
    chk("a_coll_data", rd[1], 64'h1122CCDD);
    chk("a_coll_flag", 64'(co[1]), 64'd1);

    op(0, 1, 0, 8'h0, 7, 64'h0, 1, 7);
    chk("a_same_rd_p0", rd[0], 64'h1122CCDD);
    chk("a_same_rd_p1", rd[1], 64'h1122CCDD);
    chk("a_same_rd_noflag", 64'(co[1]), 64'd0);

    op(0, 1, 1, 8'h0, 9, 64'h12345678, 0, 0);
    for (int a = 0; a < 8; a++) op(0, 1, 1, 8'hF, a, {$urandom, $urandom}, 0, 0);
    cnt = 0;
    for (int a = 0; a < 8; a++) begin
      req1[0] = 1'b1; addr1[0] = 9'(a);
      step();
      if (rv[1]) cnt++;
    end
    idle(0);
    chk("a_burst_pulses", 64'(cnt), 64'd8);

    for (int i = 0; i < 300; i++) begin
      rand_req(0, ($urandom_range(0, 3) == 0) ? 511 : 15);
      step();
    end
    idle(0);
    repeat (2) step();

    rst[0] = 1'b0;
    repeat (2) step();
    rst[0] = 1'b1;
    repeat (100) step();
    rst[0] = 1'b0;
    repeat (2) step();
    rst[0] = 1'b1;
    wait_ready(0, 512, "a_clear_restart_len");
    op(0, 0, 0, 8'h0, 0, 64'h0, 1, 0);
    chk("a_clr_rd0", rd[1], 64'd0);
    chk("a_clr_rd0_valid", 64'(rv[1]), 64'd1);
    op(0, 0, 0, 8'h0, 0, 64'h0, 1, 255);
    chk("a_clr_rd255", rd[1], 64'd0);
    op(0, 0, 0, 8'h0, 0, 64'h0, 1, 511);
    chk("a_clr_rd511", rd[1], 64'd0);
    for (int a = 0; a < 16; a++) op(0, 0, 0, 8'h0, 0, 64'h0, 1, a);
    repeat (2) step();

    // ---------------- DUT B: 64x16, 8 lanes, latency 2, no clear ----------------
    rst[1] = 1'b1;
    wait_ready(1, 1, "b_ready_first");
    for (int a = 0; a < 16; a++) op(1, 1, 1, 8'hFF, a, {$urandom, $urandom}, 0, 0);
    for (int a = 0; a < 16; a++) op(1, 1, 1, 8'($urandom), a, {$urandom, $urandom}, 0, 0);
    for (int a = 0; a < 16; a++) op(1, 1, 0, 8'h0, a, 64'h0, 1, a);
    repeat (3) step();

    op(1, 1, 1, 8'hFF, 3, 64'h0123456789ABCDEF, 0, 0);
    op(1, 1, 1, 8'h81, 3, 64'hFF000000000000EE, 0, 0);
    chk("b_model_addr3", mm[1][3], 64'hFF23456789ABCDEE);
    op(1, 1, 0, 8'h0, 3, 64'h0, 0, 0);
    chk("b_lat2_not_yet", 64'(rv[2]), 64'd0);
    step();
    chk("b_lat2_valid", 64'(rv[2]), 64'd1);
    chk("b_lat2_data", rd[2], 64'hFF23456789ABCDEE);
    step();

    op(1, 0, 0, 8'h0, 0, 64'h0, 1, 3);
    rst[1] = 1'b0;
    step();
    chk("b_inflight_drop1", 64'(rv[3]), 64'd0);
    step();
    chk("b_inflight_drop2", 64'(rv[3]), 64'd0);
    rst[1] = 1'b1;
    step();
    chk("b_inflight_drop3", 64'(rv[3]), 64'd0);
    chk("b_ready_after_rst", 64'(ready[1]), 64'd1);

    for (int i = 0; i < 300; i++) begin
      rand_req(1, 15);
      step();
    end
    idle(1);
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_1rw1r_param.md
Name: sram_1rw1r_param

Overview:
- Parametrised successor to the fixed 32x512 OpenRAM 1RW1R behavioural macro model.
- Single-clock, synthesizable dual-port memory: one read/write port (p0) and one read-only port (p1).
- Adds generic width, depth and mask granularity; a post-reset clear sequencer; selectable read latency; valid strobes; and defined write-first collision behaviour.
- Sits behind the Wishbone/user-logic glue wherever the hard SRAM macro is not used (FPGA builds, small scratch RAMs).

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of WMASK_WIDTH.
- ADDR_WIDTH, 9: address bits; DEPTH = 2**ADDR_WIDTH.
- WMASK_WIDTH, 4: number of write-enable lanes; lane width = DATA_WIDTH/WMASK_WIDTH.
- READ_LATENCY, 1: cycles from accepted read to rvalid; legal values 1 or 2.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset before accepting requests; 0 = ready immediately.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ready  out  1  high when requests are accepted.
- p0_req  in  1  port 0 request strobe.
- p0_we  in  1  1 = write, 0 = read.
- p0_wmask  in  WMASK_WIDTH  per-lane write enable.
- p0_addr  in  ADDR_WIDTH  port 0 address.
- p0_wdata  in  DATA_WIDTH  write data.
- p0_rdata  out  DATA_WIDTH  port 0 read data.
- p0_rvalid  out  1  one-cycle pulse, p0_rdata valid.
- p1_req  in  1  port 1 read strobe.
- p1_addr  in  ADDR_WIDTH  port 1 address.
- p1_rdata  out  DATA_WIDTH  port 1 read data.
- p1_rvalid  out  1  one-cycle pulse, p1_rdata valid.
- collision  out  1  pulse coincident with p1_rvalid when that read hit a same-cycle p0 write.

Behaviour:
- Reset (async assert, sync release):
  - ready=0, p0_rdata=p1_rdata=0, rvalid=0, collision=0.
  - Read pipelines are flushed and the clear counter is set to 0.
  - State goes to CLEAR if CLEAR_ON_RESET=1, else RUN.
  - Memory array is not reset, except by CLEAR.
- FSM states: CLEAR, RUN.
- CLEAR state:
  - Each cycle writes 0 to mem[cnt] and increments cnt.
  - When cnt==DEPTH-1 that word is written, then the FSM goes to RUN; ready=1 from the next cycle.
  - Total DEPTH cycles with ready=0.
  - All requests are ignored: no write, no rvalid.
  - Reset asserted mid-CLEAR restarts at cnt=0.
- RUN state: ready=1; the FSM stays in RUN until reset.
- Acceptance: a request is accepted on a rising edge where req=1 and ready=1.
- p0 write:
  - Lane i of mem[p0_addr] is updated on the accepting edge iff p0_wmask[i]=1.
  - wmask=0 is accepted as a no-op. No rvalid is produced for writes.
- Reads (either port):
  - READ_LATENCY=1: rdata/rvalid update on the edge after acceptance, i.e. visible in cycle N+1 for acceptance in cycle N.
  - READ_LATENCY=2: one extra output register stage; visible in N+2.
  - Back-to-back reads every cycle are supported; rvalid is high for each.
  - rdata holds its last value when rvalid=0.
- Collision (p0 write and p1 read, same address, same cycle):
  - Write-first: p1 returns the merged word (masked lanes = new p0_wdata, other lanes = old content).
  - collision=1 with that p1_rvalid.
- p0 and p1 reads of the same address in the same cycle: both return the same data; no collision flag.
- All addresses 0..DEPTH-1 are legal; no out-of-range case exists.
- Reset mid-read: pending rvalids are discarded and never emitted.

Decomposition:
- Package sram_pkg holds:
  - enum sram_state_e {CLEAR, RUN}.
  - Functions/localparams for DEPTH and LANE_W.
  - A lane-merge function (old, new, mask) used by both the write path and the collision bypass.
- Sub-module sram_read_pipe (params DATA_WIDTH, READ_LATENCY, COLL): registers rdata/rvalid/collision for one port. Instantiated twice; p0's collision input is tied 0.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=512 -> ready low exactly 512 cycles after rst_n rises; p1 reads of addrs 0, 255, 511 return 0.
- Write 0xDEADBEEF to addr 5 with wmask=4'b1111, then wmask=4'b0010 with data 0x0000AA00 -> p0 read of addr 5 gives 0xDEADAAEF, rvalid 1 cycle later (2 with READ_LATENCY=2).
- Same cycle: p0 write 0x11223344 mask 4'b1100 to addr 7 (old 0xAABBCCDD) and p1 read addr 7 -> p1_rdata=0x1122CCDD, collision=1 coincident with p1_rvalid.
- p1_req held high for 8 cycles over addrs 0..7 -> 8 consecutive rvalid pulses with data in order.
- rst_n pulsed low during CLEAR at cnt=100 and during an in-flight read -> no rvalid emitted; clear restarts, ready after a full 512 cycles.
- CLEAR_ON_RESET=0, DATA_WIDTH=64, WMASK_WIDTH=8, ADDR_WIDTH=4 -> ready=1 in the first cycle after reset; per-byte masked writes across all 16 addresses read back correctly on both ports.
